uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver; the receive-side counterpart of the UART transmitter in the low-power multi-clock communication system. Detects a start bit on the serial line and recovers each bit by 3-sample majority voting at mid-bit. Checks optional parity and the stop bit, then presents the byte on a parallel bus with a one-cycle valid pulse. Sits in the UART clock domain; the parallel output feeds the data synchronizer toward the system domain.

## Interface
- DATA_WIDTH, 8, payload bits per frame, LSB first
- CLK  in  1  receiver clock (Prescale × baud)
- RST  in  1  asynchronous, active-high reset
- RX_IN  in  1  serial line, idle high; already synchronized upstream
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32
- P_DATA  out  DATA_WIDTH  received payload; held until next good frame
- data_valid  out  1  one-cycle pulse: P_DATA is a new, error-free byte
- par_err  out  1  one-cycle pulse: parity mismatch in the frame just ended
- stp_err  out  1  one-cycle pulse: stop bit sampled low

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: edge_cnt = 0, bit_cnt = 0. RX_IN = 0 → START.
- Every non-IDLE state:
  - edge_cnt counts 0..Prescale−1 per bit period, wrapping to 0.
  - Samples are taken at edge_cnt = Prescale/2−1, Prescale/2 and Prescale/2+1.
  - sampled_bit = majority of the three samples, valid from edge_cnt = Prescale/2+2.
- START: at edge_cnt = Prescale−1:
  - sampled_bit = 1 → glitch; return to IDLE with no flags.
  - Otherwise → DATA.
- DATA: at each bit end, shift sampled_bit into the deserializer at position bit_cnt (LSB first) and increment bit_cnt.
  - After bit DATA_WIDTH−1 → PARITY if PAR_EN, else STOP.
- PARITY: at bit end, compare sampled_bit with the expected parity:
  - Even: XOR of the data.
  - Odd: inverted XOR.
  - Store the mismatch in par_fail → STOP.
- STOP: at bit end → IDLE. The frame result is registered at the same edge:
  - stp_err = ~sampled_bit.
  - par_err = par_fail.
  - data_valid = sampled_bit & ~par_fail; P_DATA updates only when data_valid.
- PAR_EN, PAR_TYP and Prescale are captured on IDLE→START and held for the whole frame.
- Both errors in one frame: both flags pulse together; data_valid stays low.
- Reset values: P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, state IDLE, counters 0.
- Reset mid-frame aborts the frame; no flags are produced.
- Illegal Prescale (not 8/16/32) is unsupported; behaviour is undefined.

## Timing
- Cycle 0 is the first CLK edge sampling RX_IN = 0 in IDLE.
- Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- The flag pulse (data_valid/par_err/stp_err) is registered at the edge ending cycle N·Prescale − 1 and is visible high during cycle N·Prescale.
  - Example: 8N1, Prescale 8 → flags visible during cycle 80.
- Back-to-back frames: the FSM is in IDLE at cycle N·Prescale. A start bit beginning in that cycle is accepted with zero dead cycles.
- Pulses are exactly one cycle wide. P_DATA is stable from the data_valid cycle until the next data_valid.
- Tolerance: correct reception for a transmitter baud deviation of ±3 % at Prescale 16.

## Structure
- Shared package uart_pkg:
  - FSM state enum.
  - PAR_EVEN = 0, PAR_ODD = 1.
  - Legal Prescale constants.
  - Shared with the transmitter.
- Sub-module uart_rx_sampler:
  - Contains the edge counter, three-sample capture and majority vote.
  - Outputs edge_cnt, sampled_bit and bit_end strobe.
  - Enabled by the FSM while not in IDLE.
- Top holds the FSM, bit counter, deserializer, parity check and output registers.

## Test plan
- 8N1, Prescale 8, byte 0xA5 → data_valid high in cycle 80 only, P_DATA = 0xA5, no errors.
- 8E1, Prescale 16, byte 0x3C, correct even parity (0) → data_valid, P_DATA = 0x3C. Repeat with the parity bit forced to 1 → par_err pulse, no data_valid, P_DATA unchanged.
- 8O1, Prescale 32, byte 0xFF, stop bit driven low → stp_err pulse, no data_valid. Line then returns high and a 0x00 frame → recovered cleanly.
- RX_IN low for 3 cycles only, Prescale 16 → FSM returns to IDLE after 16 cycles; no flags; following 0x81 frame received correctly.
- Single-cycle glitch inside a data bit's sampling window at Prescale 16 → majority vote rejects it; byte intact. Two back-to-back frames 0x12, 0x34 with no idle gap → two data_valid pulses exactly N·Prescale apart.
- RST asserted mid-DATA of a 0x55 frame → all outputs 0 immediately; no pulse. Next full frame 0xC3 after release → received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, legal prescales.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and majority vote.
// Counter is held at zero while disabled so a frame starts at edge 0.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [5:0] i_prescale,
  input  logic       i_rx,
  output logic [5:0] o_edge_cnt,
  output logic       o_sampled_bit,
  output logic       o_bit_end
);

  logic [5:0] r_edge_cnt;
  logic [2:0] r_smp;
  logic [5:0] w_half;
  logic [5:0] w_last;
  logic       w_wrap;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - 6'd1;
  assign w_wrap = (r_edge_cnt == w_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge_cnt <= '0;
      r_smp      <= '0;
    end else if (!i_en) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
      if (r_edge_cnt == w_half - 6'd1) r_smp[0] <= i_rx;
      if (r_edge_cnt == w_half)        r_smp[1] <= i_rx;
      if (r_edge_cnt == w_half + 6'd1) r_smp[2] <= i_rx;
    end
  end

  assign o_edge_cnt    = r_edge_cnt;
  assign o_sampled_bit = majority3(r_smp);
  assign o_bit_end     = i_en & w_wrap;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, deserializer, parity and
// stop checks, registered one-cycle result flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  uart_state_e r_state;
  uart_state_e w_next;

  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;
  logic [5:0]            r_prescale;

  logic       w_en;
  logic [5:0] w_edge_cnt;
  logic       w_bit;
  logic       w_bit_end;
  logic       w_good_stop;
  logic       w_start;

  assign w_en        = (r_state != ST_IDLE);
  assign w_good_stop = (r_state == ST_STOP) & w_bit_end & w_bit & ~r_par_fail;
  // A clean stop with the line already low chains straight into the next start
  assign w_start     = ((r_state == ST_IDLE) & ~RX_IN)
                     | ((r_state == ST_STOP) & w_bit_end & w_bit & ~RX_IN);

  uart_rx_sampler u_smp (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_en          (w_en),
    .i_prescale    (r_prescale),
    .i_rx          (RX_IN),
    .o_edge_cnt    (w_edge_cnt),
    .o_sampled_bit (w_bit),
    .o_bit_end     (w_bit_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (!RX_IN) w_next = ST_START;
      ST_START:  if (w_bit_end) w_next = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (w_bit_end && r_bit_cnt == LAST)
          w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_end) w_next = w_start ? ST_START : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_prescale <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (w_start) begin
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_prescale <= Prescale;
        r_bit_cnt  <= '0;
        r_par_fail <= 1'b0;
      end
      if (r_state == ST_DATA && w_bit_end) begin
        r_shift[r_bit_cnt] <= w_bit;
        r_bit_cnt          <= r_bit_cnt + 1'b1;
      end
      if (r_state == ST_PARITY && w_edge_cnt == r_prescale - 6'd1)
        r_par_fail <= w_bit ^ (^r_shift) ^ r_par_typ;
      if (r_state == ST_STOP && w_bit_end) begin
        stp_err    <= ~w_bit;
        par_err    <= r_par_fail;
        data_valid <= w_good_stop;
        if (w_good_stop) P_DATA <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, flags logged
// on the falling edge with cycle stamps and checked per scenario.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int         dv_n, pe_n, se_n;
  int         dv_cyc [4];
  logic [7:0] dv_dat [4];
  int         pe_cyc, se_cyc;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (data_valid) begin
        if (dv_n < 4) begin
          dv_cyc[dv_n] = cyc;
          dv_dat[dv_n] = P_DATA;
        end
        dv_n = dv_n + 1;
      end
      if (par_err) begin
        pe_cyc = cyc;
        pe_n = pe_n + 1;
      end
      if (stp_err) begin
        se_cyc = cyc;
        se_n = se_n + 1;
      end
    end
  end

  task automatic clr_mon();
    dv_n = 0;
    pe_n = 0;
    se_n = 0;
    pe_cyc = -1;
    se_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      dv_cyc[i] = -1;
      dv_dat[i] = 8'hxx;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int p, input logic g);
    for (int i = 0; i < p; i++) begin
      RX_IN = (g && i == p / 2 + 1) ? ~b : b;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic pflip, input logic stopv,
                            input int gbit, output int t0);
    logic par;
    par = PAR_TYP ? ~(^d) : (^d);
    t0 = cyc;
    drive_bit(1'b0, p, 1'b0);
    for (int j = 0; j < 8; j++) drive_bit(d[j], p, gbit == j);
    if (PAR_EN) drive_bit(par ^ pflip, p, 1'b0);
    drive_bit(stopv, p, 1'b0);
    RX_IN = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (P_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_pdata: got %h expected 00", P_DATA);
    end
    n_vec++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000",
               {data_valid, par_err, stp_err});
    end
    RST = 1'b0;
    idle(4);
  endtask

  task automatic test_8n1();
    int t0;
    PAR_EN = 1'b0;
    Prescale = 6'd8;
    clr_mon();
    send_frame(8'hA5, 8, 1'b0, 1'b1, -1, t0);
    idle(20);
    n_vec++;
    if (dv_n !== 1) begin
      n_bad++;
      $display("FAIL 8n1_dv_count: got %0d expected 1", dv_n);
    end
    n_vec++;
    if (dv_cyc[0] !== t0 + 1 + 80) begin
      n_bad++;
      $display("FAIL 8n1_dv_cycle: got %0d expected %0d",
               dv_cyc[0] - t0 - 1, 80);
    end
    n_vec++;
    if (P_DATA !== 8'hA5) begin
      n_bad++;
      $display("FAIL 8n1_data: got %h expected a5", P_DATA);
    end
    n_vec++;
    if (pe_n + se_n !== 0) begin
      n_bad++;
      $display("FAIL 8n1_errs: got %0d expected 0", pe_n + se_n);
    end
  endtask

  task automatic test_even_parity();
    int t0;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    Prescale = 6'd16;
    clr_mon();
    send_frame(8'h3C, 16, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("8e1_dv_count", dv_n, 1);
    chk("8e1_dv_cycle", dv_cyc[0], t0 + 1 + 176);
    n_vec++;
    if (P_DATA !== 8'h3C) begin
      n_bad++;
      $display("FAIL 8e1_data: got %h expected 3c", P_DATA);
    end
    chk("8e1_par_err", pe_n, 0);
    clr_mon();
    send_frame(8'h3C, 16, 1'b1, 1'b1, -1, t0);
    idle(20);
    chk("8e1bad_dv_count", dv_n, 0);
    chk("8e1bad_pe_count", pe_n, 1);
    chk("8e1bad_pe_cycle", pe_cyc, t0 + 1 + 176);
    chk("8e1bad_se_count", se_n, 0);
    n_vec++;
    if (P_DATA !== 8'h3C) begin
      n_bad++;
      $display("FAIL 8e1bad_hold: got %h expected 3c", P_DATA);
    end
  endtask

  task automatic test_stop_err();
    int t0;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    Prescale = 6'd32;
    clr_mon();
    send_frame(8'hFF, 32, 1'b0, 1'b0, -1, t0);
    idle(64);
    chk("8o1_se_count", se_n, 1);
    chk("8o1_se_cycle", se_cyc, t0 + 1 + 352);
    chk("8o1_dv_count", dv_n, 0);
    chk("8o1_pe_count", pe_n, 0);
    clr_mon();
    send_frame(8'h00, 32, 1'b0, 1'b1, -1, t0);
    idle(40);
    chk("8o1_rec_dv", dv_n, 1);
    chk("8o1_rec_cycle", dv_cyc[0], t0 + 1 + 352);
    n_vec++;
    if (P_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL 8o1_rec_data: got %h expected 00", P_DATA);
    end
    chk("8o1_rec_errs", pe_n + se_n, 0);
  endtask

  task automatic test_false_start();
    int t0;
    PAR_EN = 1'b0;
    Prescale = 6'd16;
    clr_mon();
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    idle(40);
    chk("glitch_start_flags", dv_n + pe_n + se_n, 0);
    send_frame(8'h81, 16, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("glitch_next_dv", dv_n, 1);
    chk("glitch_next_cycle", dv_cyc[0], t0 + 1 + 160);
    n_vec++;
    if (P_DATA !== 8'h81) begin
      n_bad++;
      $display("FAIL glitch_next_data: got %h expected 81", P_DATA);
    end
  endtask

  task automatic test_majority();
    int t0;
    PAR_EN = 1'b0;
    Prescale = 6'd16;
    clr_mon();
    send_frame(8'h6B, 16, 1'b0, 1'b1, 2, t0);
    idle(20);
    chk("vote_dv", dv_n, 1);
    n_vec++;
    if (P_DATA !== 8'h6B) begin
      n_bad++;
      $display("FAIL vote_data: got %h expected 6b", P_DATA);
    end
    clr_mon();
    send_frame(8'h94, 16, 1'b0, 1'b1, 4, t0);
    idle(20);
    n_vec++;
    if (dv_dat[0] !== 8'h94) begin
      n_bad++;
      $display("FAIL vote_data2: got %h expected 94", dv_dat[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    PAR_EN = 1'b0;
    Prescale = 6'd16;
    clr_mon();
    send_frame(8'h12, 16, 1'b0, 1'b1, -1, t0);
    send_frame(8'h34, 16, 1'b0, 1'b1, -1, t1);
    idle(20);
    chk("b2b_dv_count", dv_n, 2);
    chk("b2b_first_cycle", dv_cyc[0], t0 + 1 + 160);
    chk("b2b_spacing", dv_cyc[1] - dv_cyc[0], 160);
    n_vec++;
    if (dv_dat[0] !== 8'h12 || dv_dat[1] !== 8'h34) begin
      n_bad++;
      $display("FAIL b2b_data: got %h %h expected 12 34",
               dv_dat[0], dv_dat[1]);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] d;
    d = 8'h55;
    PAR_EN = 1'b0;
    Prescale = 6'd16;
    clr_mon();
    drive_bit(1'b0, 16, 1'b0);
    for (int j = 0; j < 4; j++) drive_bit(d[j], 16, 1'b0);
    RST = 1'b1;
    #1;
    n_vec++;
    if (P_DATA !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_pdata: got %h expected 00", P_DATA);
    end
    n_vec++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_flags: got %b expected 000",
               {data_valid, par_err, stp_err});
    end
    idle(3);
    RST = 1'b0;
    idle(200);
    chk("rstmid_no_pulse", dv_n + pe_n + se_n, 0);
    send_frame(8'hC3, 16, 1'b0, 1'b1, -1, t0);
    idle(20);
    chk("rstmid_next_dv", dv_n, 1);
    chk("rstmid_next_cycle", dv_cyc[0], t0 + 1 + 160);
    n_vec++;
    if (P_DATA !== 8'hC3) begin
      n_bad++;
      $display("FAIL rstmid_next_data: got %h expected c3", P_DATA);
    end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_8n1();
    test_even_parity();
    test_stop_err();
    test_false_start();
    test_majority();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
